fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 114 +++++++++++
 tb/tb_fetch_buffer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: one in-flight imem request, DEPTH-entry {pc, insn} FIFO.
// Define FETCH_BUFFER_ECALL_HALT_EN to halt fetch once an ecall is enqueued.
module fetch_buffer #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int                DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_i,
  input  logic [AWIDTH-1:0]            redirect_pc_i,
  output logic                         imem_req_o,
  output logic [AWIDTH-1:0]            imem_addr_o,
  input  logic                         imem_valid_i,
  input  logic [DWIDTH-1:0]            imem_insn_i,
  output logic                         dec_valid_o,
  input  logic                         dec_ready_i,
  output logic [AWIDTH-1:0]            dec_pc_o,
  output logic [DWIDTH-1:0]            dec_insn_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         halted_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [AWIDTH-1:0] r_pc;
  logic              r_if_v;
  logic [AWIDTH-1:0] r_if_pc;
  logic [AWIDTH-1:0] r_q_pc   [DEPTH];
  logic [DWIDTH-1:0] r_q_insn [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic [CW:0]       w_occ;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_nempty;
  logic              w_halted;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_occ    = {1'b0, r_count} + {{CW{1'b0}}, r_if_v};
  assign w_req    = rst & ~redirect_i & ~w_halted & (w_occ < DEPTH_W);
  assign w_push   = r_if_v & imem_valid_i & ~redirect_i;
  assign w_nempty = (r_count != '0);
  assign w_pop    = dec_valid_o & dec_ready_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign dec_valid_o = w_nempty & ~redirect_i;
  assign dec_pc_o    = w_nempty ? r_q_pc[r_rptr] : '0;
  assign dec_insn_o  = w_nempty ? r_q_insn[r_rptr] : '0;
  assign count_o     = r_count;
  assign halted_o    = w_halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= BASEADDR;
      r_if_v  <= 1'b0;
      r_if_pc <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_insn[i] <= '0;
      end
    end else begin
      r_if_v  <= w_req;
      r_if_pc <= r_pc;
      // redirect flushes everything queued this cycle, including the response
      if (redirect_i) begin
        r_pc    <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_req) r_pc <= r_pc + AWIDTH'(4);
        if (w_push) begin
          r_q_pc[r_wptr]   <= r_if_pc;
          r_q_insn[r_wptr] <= imem_insn_i;
          r_wptr           <= f_inc(r_wptr);
        end
        if (w_pop) r_rptr <= f_inc(r_rptr);
        if (w_push && !w_pop) r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef FETCH_BUFFER_ECALL_HALT_EN
  localparam logic [DWIDTH-1:0] ECALL = DWIDTH'(32'h00000073);
  logic r_halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_halted <= 1'b0;
    else if (redirect_i) r_halted <= 1'b0;
    else if (w_push && imem_insn_i == ECALL) r_halted <= 1'b1;
  end

  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer.
// One-cycle-latency memory model.
module tb_fetch_buffer;

  localparam logic [31:0] BASE = 32'h01000000;
`ifdef FETCH_BUFFER_ECALL_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_insn_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_insn_o;
  logic [2:0]  count_o;
  logic        halted_o;

  int checks = 0;
  int errors = 0;

  logic        mq_v = 1'b0;
  logic [31:0] mq_a = '0;
  bit          ecall_mode;
  logic [31:0] exp_pc;
  bit          found;

  fetch_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_valid_i  (imem_valid_i),
    .imem_insn_i   (imem_insn_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pc_o      (dec_pc_o),
    .dec_insn_o    (dec_insn_o),
    .count_o       (count_o),
    .halted_o      (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(
    input logic [31:0] a,
    input bit em
  );
    if (em && a == BASE + 32'd8)
      return 32'h00000073;
    return a ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    mq_v <= imem_req_o;
    mq_a <= imem_addr_o;
  end

  task automatic cycle();
    @(negedge clk);
    imem_valid_i = mq_v;
    imem_insn_i  = word(mq_a, ecall_mode);
  endtask

  task automatic fail(
    input string tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    errors++;
    $error("FAIL %s: observed %0h expected %0h",
           tag, o, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_valid_i = 1'b0; imem_insn_i = '0;
    dec_ready_i = 1'b1; ecall_mode = 1'b0;

    repeat (3) cycle();
    #1;
    checks++;
    if (imem_req_o !== 1'b0)
      fail("rst_req", imem_req_o, 1'b0);
    checks++;
    if (imem_addr_o !== BASE)
      fail("rst_addr", imem_addr_o, BASE);
    checks++;
    if (dec_valid_o !== 1'b0)
      fail("rst_dv", dec_valid_o, 1'b0);
    checks++;
    if (dec_pc_o !== 32'h0)
      fail("rst_pc", dec_pc_o, 32'h0);
    checks++;
    if (dec_insn_o !== 32'h0)
      fail("rst_insn", dec_insn_o, 32'h0);
    checks++;
    if (count_o !== 3'd0)
      fail("rst_count", count_o, 3'd0);
    checks++;
    if (halted_o !== 1'b0)
      fail("rst_halt", halted_o, 1'b0);

    cycle();
    rst = 1'b1;
    imem_valid_i = 1'b1;
    imem_insn_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (imem_req_o !== 1'b1)
      fail("c0_req", imem_req_o, 1'b1);
    checks++;
    if (imem_addr_o !== BASE)
      fail("c0_addr", imem_addr_o, BASE);
    cycle(); #1;
    checks++;
    if (count_o !== 3'd0)
      fail("c1_stray", count_o, 3'd0);
    checks++;
    if (dec_valid_o !== 1'b0)
      fail("c1_dv", dec_valid_o, 1'b0);
    checks++;
    if (imem_addr_o !== BASE + 32'd4)
      fail("c1_addr", imem_addr_o, BASE + 32'd4);

    exp_pc = BASE;
    for (int k = 2; k < 8; k++) begin
      cycle(); #1;
      checks++;
      if (dec_valid_o !== 1'b1)
        fail("tp_dv", dec_valid_o, 1'b1);
      checks++;
      if (dec_pc_o !== exp_pc)
        fail("tp_pc", dec_pc_o, exp_pc);
      checks++;
      if (dec_insn_o !== word(exp_pc, 1'b0))
        fail("tp_insn", dec_insn_o, word(exp_pc, 1'b0));
      checks++;
      if (imem_addr_o !== BASE + 32'(4 * k))
        fail("tp_addr", imem_addr_o, BASE + 32'(4 * k));
      checks++;
      if (count_o !== 3'd1)
        fail("tp_count", count_o, 3'd1);
      exp_pc += 32'd4;
    end

    cycle();
    dec_ready_i = 1'b0;
    repeat (3) cycle();
    #1;
    checks++;
    if (count_o !== 3'd4)
      fail("stall_count", count_o, 3'd4);
    checks++;
    if (imem_req_o !== 1'b0)
      fail("stall_req", imem_req_o, 1'b0);
    checks++;
    if (dec_pc_o !== exp_pc)
      fail("stall_pc", dec_pc_o, exp_pc);
    repeat (6) cycle();
    #1;
    checks++;
    if (count_o !== 3'd4)
      fail("stall_count2", count_o, 3'd4);
    checks++;
    if (imem_req_o !== 1'b0)
      fail("stall_req2", imem_req_o, 1'b0);

    cycle();
    dec_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (dec_valid_o !== 1'b1)
        fail("drain_dv", dec_valid_o, 1'b1);
      checks++;
      if (dec_pc_o !== exp_pc)
        fail("drain_pc", dec_pc_o, exp_pc);
      checks++;
      if (dec_insn_o !== word(exp_pc, 1'b0))
        fail("drain_insn", dec_insn_o,
             word(exp_pc, 1'b0));
      exp_pc += 32'd4;
      cycle();
    end

    dec_ready_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      #1;
      if (count_o == 3'd3 && !imem_req_o) found = 1'b1;
      else cycle();
    end
    checks++;
    if (found !== 1'b1)
      fail("r24_setup", found, 1'b1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h01000102;
    #1;
    checks++;
    if (dec_valid_o !== 1'b0)
      fail("r24_dv_mask", dec_valid_o, 1'b0);
    checks++;
    if (imem_req_o !== 1'b0)
      fail("r24_req_mask", imem_req_o, 1'b0);
    cycle();
    redirect_i = 1'b0;
    imem_valid_i = 1'b1;
    imem_insn_i = 32'hBAD0BAD0;
    #1;
    checks++;
    if (count_o !== 3'd0)
      fail("r24_count", count_o, 3'd0);
    checks++;
    if (imem_req_o !== 1'b1)
      fail("r24_req", imem_req_o, 1'b1);
    checks++;
    if (imem_addr_o !== 32'h01000100)
      fail("r24_addr", imem_addr_o, 32'h01000100);
    dec_ready_i = 1'b1;
    cycle(); #1;
    checks++;
    if (count_o !== 3'd0)
      fail("r24_stale", count_o, 3'd0);
    checks++;
    if (imem_addr_o !== 32'h01000104)
      fail("r24_addr2", imem_addr_o, 32'h01000104);
    cycle(); #1;
    checks++;
    if (dec_pc_o !== 32'h01000100)
      fail("r24_head", dec_pc_o, 32'h01000100);
    checks++;
    if (dec_insn_o !== word(32'h01000100, 1'b0))
      fail("r24_hinsn", dec_insn_o,
           word(32'h01000100, 1'b0));

    cycle();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h01000040;
    #1;
    checks++;
    if (dec_valid_o !== 1'b0)
      fail("r25_dv_mask", dec_valid_o, 1'b0);
    cycle();
    redirect_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0)
      fail("r25_count", count_o, 3'd0);
    checks++;
    if (imem_addr_o !== 32'h01000040)
      fail("r25_addr", imem_addr_o, 32'h01000040);
    checks++;
    if (imem_req_o !== 1'b1)
      fail("r25_req", imem_req_o, 1'b1);
    cycle(); #1;
    checks++;
    if (count_o !== 3'd0)
      fail("r25_count2", count_o, 3'd0);
    cycle(); #1;
    checks++;
    if (dec_pc_o !== 32'h01000040)
      fail("r25_head", dec_pc_o, 32'h01000040);

    cycle();
    redirect_i = 1'b1;
    redirect_pc_i = BASE;
    ecall_mode = 1'b1;
    cycle();
    redirect_i = 1'b0;
    #1;
    checks++;
    if (imem_addr_o !== BASE)
      fail("ec_addr", imem_addr_o, BASE);
    repeat (4) cycle();
    #1;
    ecall_mode = 1'b0;
    checks++;
    if (dec_pc_o !== BASE + 32'd8)
      fail("ec_pc", dec_pc_o, BASE + 32'd8);
    checks++;
    if (dec_insn_o !== 32'h00000073)
      fail("ec_insn", dec_insn_o, 32'h00000073);
    checks++;
    if (halted_o !== HALT)
      fail("ec_halt", halted_o, HALT);
    checks++;
    if (imem_req_o !== !HALT)
      fail("ec_req", imem_req_o, !HALT);
    cycle(); cycle(); #1;
    checks++;
    if (imem_req_o !== !HALT)
      fail("ec_req2", imem_req_o, !HALT);
    checks++;
    if (halted_o !== HALT)
      fail("ec_halt2", halted_o, HALT);
    checks++;
    if (count_o !== (HALT ? 3'd0 : 3'd1))
      fail("ec_count", count_o, HALT ? 3'd0 : 3'd1);
    cycle();
    redirect_i = 1'b1;
    redirect_pc_i = BASE;
    #1;
    checks++;
    if (halted_o !== HALT)
      fail("ec_halt_hold", halted_o, HALT);
    cycle();
    redirect_i = 1'b0;
    #1;
    checks++;
    if (halted_o !== 1'b0)
      fail("ec_clear", halted_o, 1'b0);
    checks++;
    if (imem_req_o !== 1'b1)
      fail("ec_restart", imem_req_o, 1'b1);
    checks++;
    if (imem_addr_o !== BASE)
      fail("ec_raddr", imem_addr_o, BASE);

    dec_ready_i = 1'b0;
    repeat (6) cycle();
    #1;
    checks++;
    if (count_o !== 3'd4)
      fail("r27_full", count_o, 3'd4);
    rst = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0)
      fail("r27_count", count_o, 3'd0);
    checks++;
    if (dec_valid_o !== 1'b0)
      fail("r27_dv", dec_valid_o, 1'b0);
    checks++;
    if (dec_pc_o !== 32'h0)
      fail("r27_pc", dec_pc_o, 32'h0);
    checks++;
    if (dec_insn_o !== 32'h0)
      fail("r27_insn", dec_insn_o, 32'h0);
    checks++;
    if (imem_req_o !== 1'b0)
      fail("r27_req", imem_req_o, 1'b0);
    checks++;
    if (halted_o !== 1'b0)
      fail("r27_halt", halted_o, 1'b0);
    checks++;
    if (imem_addr_o !== BASE)
      fail("r27_addr", imem_addr_o, BASE);
    cycle();
    rst = 1'b1;
    dec_ready_i = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b1)
      fail("r27_req1", imem_req_o, 1'b1);
    checks++;
    if (imem_addr_o !== BASE)
      fail("r27_addr1", imem_addr_o, BASE);
    cycle(); #1;
    checks++;
    if (imem_addr_o !== BASE + 32'd4)
      fail("r27_addr2", imem_addr_o, BASE + 32'd4);
    cycle(); #1;
    checks++;
    if (dec_pc_o !== BASE)
      fail("r27_head", dec_pc_o, BASE);
    checks++;
    if (dec_insn_o !== word(BASE, 1'b0))
      fail("r27_hinsn", dec_insn_o, word(BASE, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
